fetch_queue: RTL

- Instruction fetch queue that sits directly downstream of the cacheline parser stage and feeds the decoder.
- Buffers each extracted 32-bit instruction word together with its tag/index/offset address fields.
- Presents entries to decode with a valid/ready handshake and supports pipeline flush.
- The parser cannot stall, so the queue raises an early stall request toward fetch with enough slack to absorb words already in flight.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue_mem.sv | 24 ++
 rtl/fetch_queue.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path widths and the instruction entry payload carried from parser to decode.
package fetch_pkg;

  localparam int unsigned OFFSET_W    = 5;
  localparam int unsigned INDEX_W     = 8;
  localparam int unsigned TAG_W       = 64 - (OFFSET_W + INDEX_W);
  localparam int unsigned PAYLOAD_W   = 32;
  localparam int unsigned DEPTH_LOG2  = 3;
  localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
  localparam int unsigned STALL_SLACK = 2;
  localparam int unsigned PTR_W       = DEPTH_LOG2 + 1;
  localparam int unsigned COUNT_W     = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     tag;
    logic [INDEX_W-1:0]   index;
    logic [OFFSET_W-1:0]  offset;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
module fetch_queue_mem
  import fetch_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  fetch_entry_t          wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output fetch_entry_t          rd_data
);

  fetch_entry_t mem_q [DEPTH];

  // Write port; contents are not reset since the pointers qualify every read.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the cacheline parser and decode, with early stall and sticky overflow.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 flush_i,
  input  logic                 enable_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [TAG_W-1:0]     tag_i,
  input  logic [INDEX_W-1:0]   index_i,
  input  logic [OFFSET_W-1:0]  offset_i,
  output logic                 stall_o,
  output logic                 overflow_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic [INDEX_W-1:0]   index_o,
  output logic [OFFSET_W-1:0]  offset_o,
  output logic [COUNT_W-1:0]   count_o
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               stall_q, stall_d;
  logic               ovf_q, ovf_d;

  logic               empty_c, full_c, push_c, pop_c, mem_we_c;
  fetch_entry_t       wr_entry, rd_entry;

  assign wr_entry = '{payload: payload_i, tag: tag_i, index: index_i, offset: offset_i};

  // Occupancy flags and handshake qualification; a full queue still accepts when the head leaves.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    pop_c    = !empty_c && ready_i;
    push_c   = enable_i && (!full_c || pop_c);
    mem_we_c = push_c && !flush_i;
  end

  // Next pointers and registered status; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    stall_d  = stall_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      stall_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = COUNT_W'(wr_ptr_d - rd_ptr_d);
      valid_d = (count_d != '0);
      stall_d = ((COUNT_W'(DEPTH) - count_d) <= COUNT_W'(STALL_SLACK));
      if (enable_i && !push_c) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  fetch_queue_mem u_mem (
    .clock_i (clock_i),
    .wr_en   (mem_we_c),
    .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
    .rd_data (rd_entry)
  );

  assign count_o    = count_q;
  assign valid_o    = valid_q;
  assign stall_o    = stall_q;
  assign overflow_o = ovf_q;
  assign payload_o  = rd_entry.payload;
  assign tag_o      = rd_entry.tag;
  assign index_o    = rd_entry.index;
  assign offset_o   = rd_entry.offset;

endmodule
